// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry controller bundle: scanner key stream in, committed entry and
// multiplexed display drive out. The scanner/host side uses master, the
// controller uses slave.
interface keypad_entry_ctrl_if;
  logic        key_valid_in;
  logic [3:0]  key_code_in;
  logic [15:0] entry_value;
  logic [2:0]  entry_len;
  logic        entry_valid;
  logic        overflow;
  logic [3:0]  digit_en;
  logic [3:0]  digit_code;
  logic        digit_blank;

  modport master (
    output key_valid_in,
    output key_code_in,
    input  entry_value,
    input  entry_len,
    input  entry_valid,
    input  overflow,
    input  digit_en,
    input  digit_code,
    input  digit_blank
  );

  modport slave (
    input  key_valid_in,
    input  key_code_in,
    output entry_value,
    output entry_len,
    output entry_valid,
    output overflow,
    output digit_en,
    output digit_code,
    output digit_blank
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces the scanner stream into one event per
// press, edits a 4-digit BCD buffer (digits, backspace, clear, commit) and
// scans the in-progress buffer onto a 4-digit multiplexed display.
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REFRESH_CYCLES  = 1000
) (
  input logic                clk,
  input logic                rst_n,
  keypad_entry_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_BACK   = 4'hE;
  localparam logic [3:0] KEY_COMMIT = 4'hF;
  localparam logic [3:0] KEY_MAXDIG = 4'h9;
  localparam logic [2:0] BUF_FULL   = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       latched_code;
  logic             fire;

  logic [15:0]      buffer;
  logic [2:0]       buf_len;
  logic [15:0]      entry_value_q;
  logic [2:0]       entry_len_q;
  logic             entry_valid_q;
  logic             overflow_q;

  logic [REF_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic [1:0]       next_idx;
  logic [3:0]       digit_en_q;

  // The accepting edge is the one where a stable press completes its count;
  // the action has to happen on that same edge, so this is decoded from the
  // current state and inputs rather than registered.
  assign fire = (state == DEBOUNCE) && bus.key_valid_in &&
                (bus.key_code_in == latched_code) && (cnt == CNT_LAST);

  // Debounce FSM: one event per physical press, release also debounced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      latched_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.key_valid_in) begin
            state        <= DEBOUNCE;
            latched_code <= bus.key_code_in;
            cnt          <= CNT_ONE;
          end
        end
        DEBOUNCE: begin
          if (!bus.key_valid_in) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (bus.key_code_in != latched_code) begin
            latched_code <= bus.key_code_in;
            cnt          <= CNT_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              state <= PRESSED;
            end
          end
        end
        PRESSED: begin
          if (!bus.key_valid_in) begin
            state <= RELEASE;
            cnt   <= CNT_ONE;
          end
        end
        RELEASE: begin
          if (bus.key_valid_in) begin
            state <= PRESSED;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Entry buffer editing and commit, driven by accepted key events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer        <= '0;
      buf_len       <= '0;
      entry_value_q <= '0;
      entry_len_q   <= '0;
      entry_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      entry_valid_q <= 1'b0;
      if (fire) begin
        if (latched_code <= KEY_MAXDIG) begin
          if (buf_len < BUF_FULL) begin
            buffer  <= {buffer[11:0], latched_code};
            buf_len <= buf_len + 3'd1;
          end else begin
            overflow_q <= 1'b1;
          end
        end else if (latched_code == KEY_BACK) begin
          if (buf_len != 3'd0) begin
            buffer  <= {4'h0, buffer[15:4]};
            buf_len <= buf_len - 3'd1;
          end
        end else if (latched_code == KEY_CLEAR) begin
          buffer     <= '0;
          buf_len    <= '0;
          overflow_q <= 1'b0;
        end else if (latched_code == KEY_COMMIT) begin
          entry_value_q <= buffer;
          entry_len_q   <= buf_len;
          entry_valid_q <= 1'b1;
          buffer        <= '0;
          buf_len       <= '0;
          overflow_q    <= 1'b0;
        end
      end
    end
  end

  assign next_idx = digit_idx + 2'd1;

  // Display scan: hold each digit for REFRESH_CYCLES clocks, then move on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      digit_en_q  <= 4'b1110;
    end else begin
      if (refresh_cnt == REF_LAST) begin
        refresh_cnt <= '0;
        digit_idx   <= next_idx;
        digit_en_q  <= ~(4'b0001 << next_idx);
      end else begin
        refresh_cnt <= refresh_cnt + REF_W'(1);
      end
    end
  end

  assign bus.entry_value = entry_value_q;
  assign bus.entry_len   = entry_len_q;
  assign bus.entry_valid = entry_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.digit_en    = digit_en_q;
  assign bus.digit_code  = buffer[{digit_idx, 2'b00} +: 4];
  assign bus.digit_blank = ({1'b0, digit_idx} >= buf_len);

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios plus a randomized key stream
// compared against a run-length/queue model of the keypad entry behaviour.
module tb_keypad_entry_ctrl;
  localparam int D = 4;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  keypad_entry_ctrl_if bus();

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(D), .REFRESH_CYCLES(R)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  int          mQ[$];
  bit          mOvf;
  logic [15:0] mValue;
  int          mLen;
  bit          mArmed;
  int          mHigh;
  int          mLow;
  logic [3:0]  mRunCode;
  int          mCyc;
  bit          mStrobeNow;
  int          expStrobes = 0;
  int          obsStrobes = 0;
  int          obsDouble = 0;
  bit          prevValid = 0;

  function automatic logic [15:0] model_buffer();
    logic [15:0] v = 16'h0;
    foreach (mQ[i]) v = {v[11:0], 4'(mQ[i])};
    return v;
  endfunction

  function automatic int exp_idx();
    return (mCyc / R) % 4;
  endfunction

  function automatic logic [3:0] exp_en();
    return 4'b1111 & ~(4'b0001 << exp_idx());
  endfunction

  function automatic logic [3:0] exp_code();
    int idx = exp_idx();
    if (idx < mQ.size()) return 4'(mQ[mQ.size() - 1 - idx]);
    return 4'h0;
  endfunction

  function automatic logic exp_blank();
    return exp_idx() >= mQ.size();
  endfunction

  task automatic model_reset();
    mQ.delete();
    mOvf = 0; mValue = 16'h0; mLen = 0;
    mArmed = 1; mHigh = 0; mLow = 0; mRunCode = 4'h0;
    mCyc = 0; mStrobeNow = 0; prevValid = 0;
  endtask

  task automatic model_action(input logic [3:0] c);
    if (c <= 4'd9) begin
      if (mQ.size() < 4) mQ.push_back(int'(c));
      else mOvf = 1;
    end else if (c == 4'hE) begin
      if (mQ.size() > 0) void'(mQ.pop_back());
    end else if (c == 4'hA) begin
      mQ.delete(); mOvf = 0;
    end else if (c == 4'hF) begin
      mValue = model_buffer(); mLen = mQ.size();
      mQ.delete(); mOvf = 0;
      mStrobeNow = 1; expStrobes++;
    end
  endtask

  // An event fires when the key has been held with one code for D edges while
  // armed; the model re-arms once the key has been released for D edges.
  task automatic model_edge(input logic v, input logic [3:0] c);
    mCyc++;
    mStrobeNow = 0;
    if (v) begin
      if (mHigh > 0 && c == mRunCode) mHigh++;
      else begin mHigh = 1; mRunCode = c; end
      mLow = 0;
    end else begin
      mHigh = 0; mLow++;
    end
    if (mArmed && v && mHigh == D) begin
      mArmed = 0; model_action(c);
    end else if (!mArmed && !v && mLow == D) begin
      mArmed = 1;
    end
  endtask

  task automatic step(input logic v, input logic [3:0] c);
    bus.key_valid_in = v;
    bus.key_code_in = c;
    @(posedge clk);
    model_edge(v, c);
    #1;
    if (bus.entry_valid === 1'b1) begin
      obsStrobes++;
      if (prevValid) obsDouble++;
    end
    prevValid = (bus.entry_valid === 1'b1);
  endtask

  task automatic press_key(input logic [3:0] c);
    repeat (D) step(1'b1, c);
    repeat (D) step(1'b0, 4'h0);
  endtask

  task automatic do_reset();
    bus.key_valid_in = 1'b0;
    bus.key_code_in = 4'h0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    testsRun++; if (bus.entry_value !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_entry_value got %h want 0000", bus.entry_value); end
    testsRun++; if (bus.entry_len !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_entry_len got %0d want 0", bus.entry_len); end
    testsRun++; if (bus.entry_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_entry_valid got %b want 0", bus.entry_valid); end
    testsRun++; if (bus.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_overflow got %b want 0", bus.overflow); end
    testsRun++; if (bus.digit_en !== 4'b1110) begin testsFailed++; $display("[TB] FAIL reset_digit_en got %b want 1110", bus.digit_en); end
    testsRun++; if (bus.digit_code !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_digit_code got %h want 0", bus.digit_code); end
    testsRun++; if (bus.digit_blank !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_digit_blank got %b want 1", bus.digit_blank); end
  endtask

  task automatic test_bounce();
    int s0;
    do_reset();
    repeat (3) step(1'b1, 4'h5);
    step(1'b0, 4'h0);
    repeat (3) step(1'b1, 4'h5);
    testsRun++; if (bus.digit_blank !== 1'b1) begin testsFailed++; $display("[TB] FAIL bounce_early_accept blank got %b want 1", bus.digit_blank); end
    step(1'b1, 4'h5);
    repeat (D) step(1'b0, 4'h0);
    s0 = obsStrobes;
    press_key(4'hF);
    testsRun++; if (bus.entry_value !== 16'h0005) begin testsFailed++; $display("[TB] FAIL bounce_value got %h want 0005", bus.entry_value); end
    testsRun++; if (bus.entry_len !== 3'd1) begin testsFailed++; $display("[TB] FAIL bounce_len got %0d want 1", bus.entry_len); end
    testsRun++; if (obsStrobes - s0 !== 1) begin testsFailed++; $display("[TB] FAIL bounce_strobes got %0d want 1", obsStrobes - s0); end
  endtask

  task automatic test_held_key();
    do_reset();
    repeat (50) step(1'b1, 4'h7);
    repeat (50) step(1'b1, 4'h8);
    repeat (D) step(1'b0, 4'h0);
    press_key(4'hF);
    testsRun++; if (bus.entry_value !== 16'h0007) begin testsFailed++; $display("[TB] FAIL held_value got %h want 0007", bus.entry_value); end
    testsRun++; if (bus.entry_len !== 3'd1) begin testsFailed++; $display("[TB] FAIL held_len got %0d want 1", bus.entry_len); end
  endtask

  task automatic test_entry();
    int s0;
    do_reset();
    press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'h4);
    testsRun++; if (bus.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL entry_no_overflow got %b want 0", bus.overflow); end
    press_key(4'h9);
    testsRun++; if (bus.overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL entry_overflow got %b want 1", bus.overflow); end
    s0 = obsStrobes;
    press_key(4'hF);
    testsRun++; if (bus.entry_value !== 16'h1234) begin testsFailed++; $display("[TB] FAIL entry_value got %h want 1234", bus.entry_value); end
    testsRun++; if (bus.entry_len !== 3'd4) begin testsFailed++; $display("[TB] FAIL entry_len got %0d want 4", bus.entry_len); end
    testsRun++; if (bus.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL entry_overflow_clear got %b want 0", bus.overflow); end
    testsRun++; if (obsStrobes - s0 !== 1) begin testsFailed++; $display("[TB] FAIL entry_strobes got %0d want 1", obsStrobes - s0); end
    testsRun++; if (bus.digit_blank !== 1'b1) begin testsFailed++; $display("[TB] FAIL entry_buffer_clear blank got %b want 1", bus.digit_blank); end
  endtask

  task automatic test_edit();
    int s0;
    do_reset();
    press_key(4'h4); press_key(4'h2); press_key(4'hE); press_key(4'h6); press_key(4'hF);
    testsRun++; if (bus.entry_value !== 16'h0046) begin testsFailed++; $display("[TB] FAIL edit_value got %h want 0046", bus.entry_value); end
    testsRun++; if (bus.entry_len !== 3'd2) begin testsFailed++; $display("[TB] FAIL edit_len got %0d want 2", bus.entry_len); end
    press_key(4'h3); press_key(4'h3); press_key(4'hA);
    for (int i = 0; i < 4 * R; i++) begin
      step(1'b0, 4'h0);
      testsRun++; if (bus.digit_blank !== 1'b1) begin testsFailed++; $display("[TB] FAIL edit_clear_blank cycle %0d got %b want 1", i, bus.digit_blank); end
    end
    press_key(4'hE);
    s0 = obsStrobes;
    press_key(4'hF);
    testsRun++; if (bus.entry_value !== 16'h0000) begin testsFailed++; $display("[TB] FAIL edit_empty_value got %h want 0000", bus.entry_value); end
    testsRun++; if (bus.entry_len !== 3'd0) begin testsFailed++; $display("[TB] FAIL edit_empty_len got %0d want 0", bus.entry_len); end
    testsRun++; if (obsStrobes - s0 !== 1) begin testsFailed++; $display("[TB] FAIL edit_empty_strobe got %0d want 1", obsStrobes - s0); end
  endtask

  task automatic test_display();
    logic [3:0] enTab[4]    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] codeTab[4]  = '{4'h6, 4'h4, 4'h0, 4'h0};
    logic       blankTab[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int idx;
    do_reset();
    press_key(4'h4);
    press_key(4'h6);
    for (int i = 0; i < 5 * R; i++) begin
      step(1'b0, 4'h0);
      idx = (mCyc / R) % 4;
      testsRun++; if (bus.digit_en !== enTab[idx]) begin testsFailed++; $display("[TB] FAIL display_en cyc %0d got %b want %b", mCyc, bus.digit_en, enTab[idx]); end
      testsRun++; if (bus.digit_code !== codeTab[idx]) begin testsFailed++; $display("[TB] FAIL display_code cyc %0d got %h want %h", mCyc, bus.digit_code, codeTab[idx]); end
      testsRun++; if (bus.digit_blank !== blankTab[idx]) begin testsFailed++; $display("[TB] FAIL display_blank cyc %0d got %b want %b", mCyc, bus.digit_blank, blankTab[idx]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_key(4'h1); press_key(4'h2); press_key(4'h3);
    repeat (2) step(1'b1, 4'h5);
    #2 rst_n = 1'b0;
    #1;
    testsRun++; if (bus.entry_value !== 16'h0) begin testsFailed++; $display("[TB] FAIL midreset_entry_value got %h want 0000", bus.entry_value); end
    testsRun++; if (bus.entry_len !== 3'd0) begin testsFailed++; $display("[TB] FAIL midreset_entry_len got %0d want 0", bus.entry_len); end
    testsRun++; if (bus.overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_overflow got %b want 0", bus.overflow); end
    testsRun++; if (bus.digit_en !== 4'b1110) begin testsFailed++; $display("[TB] FAIL midreset_digit_en got %b want 1110", bus.digit_en); end
    testsRun++; if (bus.digit_code !== 4'h0) begin testsFailed++; $display("[TB] FAIL midreset_digit_code got %h want 0", bus.digit_code); end
    testsRun++; if (bus.digit_blank !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_digit_blank got %b want 1", bus.digit_blank); end
    bus.key_valid_in = 1'b1;
    bus.key_code_in = 4'h9;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (3) step(1'b1, 4'h9);
    testsRun++; if (bus.digit_blank !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_early_accept blank got %b want 1", bus.digit_blank); end
    step(1'b1, 4'h9);
    testsRun++; if (bus.digit_blank !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_accept blank got %b want 0", bus.digit_blank); end
    testsRun++; if (bus.digit_code !== 4'h9) begin testsFailed++; $display("[TB] FAIL midreset_accept code got %h want 9", bus.digit_code); end
    repeat (20) step(1'b1, 4'h9);
    repeat (D) step(1'b0, 4'h0);
    press_key(4'hF);
    testsRun++; if (bus.entry_value !== 16'h0009) begin testsFailed++; $display("[TB] FAIL midreset_value got %h want 0009", bus.entry_value); end
    testsRun++; if (bus.entry_len !== 3'd1) begin testsFailed++; $display("[TB] FAIL midreset_len got %0d want 1", bus.entry_len); end
  endtask

  task automatic test_back_to_back();
    int s0;
    do_reset();
    s0 = obsStrobes;
    press_key(4'hF);
    press_key(4'hF);
    testsRun++; if (obsStrobes - s0 !== 2) begin testsFailed++; $display("[TB] FAIL b2b_strobes got %0d want 2", obsStrobes - s0); end
    testsRun++; if (obsDouble !== 0) begin testsFailed++; $display("[TB] FAIL b2b_double_pulse got %0d want 0", obsDouble); end
    testsRun++; if (bus.entry_len !== 3'd0) begin testsFailed++; $display("[TB] FAIL b2b_len got %0d want 0", bus.entry_len); end
  endtask

  task automatic rstep(input logic v, input logic [3:0] c);
    step(v, c);
    testsRun++; if (bus.entry_valid !== mStrobeNow) begin testsFailed++; $display("[TB] FAIL rand_valid cyc %0d got %b want %b", mCyc, bus.entry_valid, mStrobeNow); end
    testsRun++; if (bus.entry_value !== mValue) begin testsFailed++; $display("[TB] FAIL rand_value cyc %0d got %h want %h", mCyc, bus.entry_value, mValue); end
    testsRun++; if (bus.entry_len !== 3'(mLen)) begin testsFailed++; $display("[TB] FAIL rand_len cyc %0d got %0d want %0d", mCyc, bus.entry_len, mLen); end
    testsRun++; if (bus.overflow !== mOvf) begin testsFailed++; $display("[TB] FAIL rand_overflow cyc %0d got %b want %b", mCyc, bus.overflow, mOvf); end
    testsRun++; if (bus.digit_en !== exp_en()) begin testsFailed++; $display("[TB] FAIL rand_digit_en cyc %0d got %b want %b", mCyc, bus.digit_en, exp_en()); end
    testsRun++; if (bus.digit_code !== exp_code()) begin testsFailed++; $display("[TB] FAIL rand_digit_code cyc %0d got %h want %h", mCyc, bus.digit_code, exp_code()); end
    testsRun++; if (bus.digit_blank !== exp_blank()) begin testsFailed++; $display("[TB] FAIL rand_digit_blank cyc %0d got %b want %b", mCyc, bus.digit_blank, exp_blank()); end
  endtask

  task automatic test_random();
    int s0, e0, r, n, changeAt, lows;
    logic [3:0] c, other;
    do_reset();
    s0 = obsStrobes;
    e0 = expStrobes;
    for (int p = 0; p < 80; p++) begin
      r = $urandom_range(0, 19);
      if (r < 10) c = 4'(r);
      else if (r < 12) c = 4'hE;
      else if (r == 12) c = 4'hA;
      else if (r < 15) c = 4'hF;
      else if (r < 18) c = 4'(r - 4);
      else c = 4'($urandom_range(0, 9));
      other = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, D - 1)) rstep(1'b1, c);
        rstep(1'b0, 4'h0);
      end
      n = $urandom_range(D, D + 5);
      changeAt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : n;
      for (int i = 0; i < n; i++) rstep(1'b1, (i >= changeAt) ? other : c);
      lows = $urandom_range(1, D + 2);
      repeat (lows) rstep(1'b0, 4'h0);
    end
    repeat (D) rstep(1'b0, 4'h0);
    testsRun++; if (obsStrobes - s0 !== expStrobes - e0) begin testsFailed++; $display("[TB] FAIL rand_strobe_count got %0d want %0d", obsStrobes - s0, expStrobes - e0); end
    testsRun++; if (obsDouble !== 0) begin testsFailed++; $display("[TB] FAIL rand_double_pulse got %0d want 0", obsDouble); end
  endtask

  // Scenario sequence
  initial begin
    bus.key_valid_in = 1'b0;
    bus.key_code_in = 4'h0;
    test_reset();
    test_bounce();
    test_held_key();
    test_entry();
    test_edit();
    test_display();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
